pll_reset_sequencer: RTL
========================

// Module: pll_reset_sequencer
// PURPOSE
// - Consumes the system PLL 'locked' output and drives the PLL 'rst' input.
// - Runs on the free-running 50 MHz board reference clock, not on a PLL output.
// - Produces staged, ordered reset releases for the fabric clocked by the PLL outputs.
// - Re-sequences on loss of lock, lock timeout or software request; exports status counters.
// PARAMETERS
// - PLL_RST_CYCLES      16     cycles pll_rst is held high per attempt (>=1)
// - LOCK_STABLE_CYCLES  1024   consecutive synced-locked cycles needed before staging (>=1)
// - LOCK_TIMEOUT        65535  max WAIT_LOCK cycles before a retry (> LOCK_STABLE_CYCLES)
// - NUM_STAGES          3      number of staged reset outputs (1..8)
// - STAGE_GAP           64     cycles between successive stage releases (>=1)
// PORTS
// - clk              in   1           free-running reference clock (50 MHz)
// - reset            in   1           synchronous, active-high
// - locked           in   1           PLL lock, asynchronous to clk
// - sw_reset_req     in   1           one-cycle pulse: re-run full sequence
// - pll_rst          out  1           to PLL rst, active-high
// - rst_out          out  NUM_STAGES  per-stage reset, active-high; bit 0 released first
// - ready            out  1           all stages released, lock stable
// - lock_loss_count  out  8           saturating count of lock losses after staging began
// - timeout_err      out  1           sticky: at least one lock timeout occurred
// BEHAVIOUR
// - reset=1 at a clk edge: state PLL_RST, all counters 0, pll_rst=1, rst_out=all 1s,
//   ready=0, lock_loss_count=0, timeout_err=0, synchroniser flops=0.
// - Mid-operation reset takes effect at that edge, with no partial state kept.
// - locked passes through a 2-FF synchroniser to give locked_s (2-cycle latency).
// - Only locked_s is used internally.
// - FSM, one registered cnt of width $clog2(max param + 1):
//   PLL_RST:
//     pll_rst=1. Go to WAIT_LOCK when cnt==PLL_RST_CYCLES-1, so pll_rst is high
//     for exactly PLL_RST_CYCLES cycles. sw_reset_req is ignored here.
//   WAIT_LOCK:
//     pll_rst=0. stable_cnt increments while locked_s=1 and clears on locked_s=0.
//     When stable_cnt reaches LOCK_STABLE_CYCLES, go to STAGE.
//     tmo_cnt counts every WAIT_LOCK cycle. At LOCK_TIMEOUT: timeout_err<=1, go to PLL_RST.
//     If stable and timeout hit on the same cycle, stable wins.
//   STAGE:
//     rst_out[i] falls STAGE_GAP*(i+1) cycles after STAGE entry.
//     One cycle after the last release: ready<=1, go to RUN.
//   RUN:
//     Hold all outputs.
// - Lock loss (locked_s==0 in STAGE or RUN):
//   - Next edge: rst_out<=all 1s, ready<=0.
//   - lock_loss_count++ (saturates at 255). Go to PLL_RST.
// - sw_reset_req in WAIT_LOCK, STAGE or RUN:
//   - Same as lock loss, but lock_loss_count is not incremented.
//   - If it coincides with a lock loss, the lock loss is counted once.
// - rst_out is monotone during STAGE: once a bit is released it stays low until a re-sequence.
// - Re-sequence asserts all bits in the same cycle.
// - All outputs are registered. No combinational path from any input to any output.
// - rst_out is consumed in the PLL output domains through per-domain reset synchronisers
//   owned by the consumers.
// STRUCTURE
// - Shared header pll_reset_seq_defs.vh:
//   - 2-bit state encodings ST_PLL_RST=0, ST_WAIT_LOCK=1, ST_STAGE=2, ST_RUN=3.
//   - Saturation limit 8'hFF.
// - One sub-module, reset_seq_sync:
//   - Parameterised-width 2-FF synchroniser.
//   - Synchronous reset to 0.
//   - Used for locked.
// - Top: FSM, shared counter, stable counter, timeout counter, stage release logic,
//   status registers.
// TESTING (PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT=32, NUM_STAGES=3, STAGE_GAP=3)
// - Reset 3 cycles, then locked=1 steady:
//   - pll_rst high exactly 4 cycles after reset drops.
//   - rst_out steps 111->110->100->000 at 3-cycle spacing.
//   - ready=1 one cycle after 000.
// - locked never rises:
//   - timeout_err=1 after 32 WAIT_LOCK cycles.
//   - pll_rst re-pulses for 4 cycles. Repeats indefinitely with ready=0.
// - locked glitches low 1 cycle at stable_cnt=5:
//   - stable count restarts.
//   - STAGE entry is delayed by the glitch plus 8 cycles. No timeout.
// - In RUN, drop locked for 1 cycle:
//   - 3 cycles later: rst_out=111, ready=0, lock_loss_count=1, pll_rst=1.
//   - Full sequence repeats.
//   - Repeat 300 times: lock_loss_count saturates at 255.
// - sw_reset_req mid-STAGE (rst_out=110) coincident with a lock drop:
//   - Single re-sequence. lock_loss_count +1.
//   - sw_reset_req while in PLL_RST has no effect.
// - Assert reset while in RUN: all outputs return to reset values at that edge.

Source files
------------

// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and constants for the PLL reset sequencer.
// State encoding, saturation limit and a small sizing helper.
package pll_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STAGE     = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  localparam logic [7:0] LOSS_SAT = 8'hFF;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_seq_sync.sv
// Parameterised-width two-flop synchroniser, sync reset to 0.
// Ports: clk, reset (sync, active-high), d (async in), q (synced out).
module reset_seq_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] ff1_q;
  logic [W-1:0] ff2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ff1_q <= '0;
      ff2_q <= '0;
    end else begin
      ff1_q <= d;
      ff2_q <= ff1_q;
    end
  end

  assign q = ff2_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives PLL rst from the reference clock and releases staged fabric
// resets once lock is stable; re-sequences on lock loss, timeout or sw.
// Ports: clk, reset (sync, active-high), locked (async), sw_reset_req,
//        pll_rst, rst_out[NUM_STAGES], ready, lock_loss_count, timeout_err.
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT       = 65535,
  parameter int NUM_STAGES         = 3,
  parameter int STAGE_GAP          = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  locked,
  input  logic                  sw_reset_req,
  output logic                  pll_rst,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  ready,
  output logic [7:0]            lock_loss_count,
  output logic                  timeout_err
);

  localparam int STAGE_END = STAGE_GAP * NUM_STAGES;
  localparam int CNT_W =
    $clog2(max2(PLL_RST_CYCLES, STAGE_END) + 1);
  localparam int STB_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] PLL_LAST =
    CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STG_LAST = CNT_W'(STAGE_END);
  localparam logic [STB_W-1:0] STB_DONE =
    STB_W'(LOCK_STABLE_CYCLES);
  localparam logic [TMO_W-1:0] TMO_DONE = TMO_W'(LOCK_TIMEOUT);

  logic locked_s;

  reset_seq_sync #(.W(1)) u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (locked),
    .q     (locked_s)
  );

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [STB_W-1:0]      stb_q, stb_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  pll_rst_q, pll_rst_d;
  logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
  logic                  ready_q, ready_d;
  logic [7:0]            loss_q, loss_d;
  logic                  terr_q, terr_d;
  logic                  resync;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stb_d     = stb_q;
    tmo_d     = tmo_q;
    pll_rst_d = pll_rst_q;
    rst_out_d = rst_out_q;
    ready_d   = ready_q;
    loss_d    = loss_q;
    terr_d    = terr_q;
    resync    = 1'b0;

    unique case (state_q)
      ST_PLL_RST: begin
        pll_rst_d = 1'b1;
        if (cnt_q == PLL_LAST) begin
          state_d   = ST_WAIT_LOCK;
          pll_rst_d = 1'b0;
          cnt_d     = '0;
          stb_d     = '0;
          tmo_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (sw_reset_req) begin
          resync = 1'b1;
        end else begin
          stb_d = locked_s ? stb_q + STB_W'(1) : '0;
          tmo_d = tmo_q + TMO_W'(1);
          // stable lock takes priority over a same-cycle timeout
          if (stb_d == STB_DONE) begin
            state_d = ST_STAGE;
            cnt_d   = '0;
          end else if (tmo_d == TMO_DONE) begin
            terr_d = 1'b1;
            resync = 1'b1;
          end
        end
      end
      ST_STAGE, ST_RUN: begin
        if (!locked_s || sw_reset_req) begin
          resync = 1'b1;
          if (!locked_s && loss_q != LOSS_SAT)
            loss_d = loss_q + 8'd1;
        end else if (state_q == ST_STAGE) begin
          for (int i = 0; i < NUM_STAGES; i++) begin
            if (cnt_q == CNT_W'(STAGE_GAP * (i + 1) - 1))
              rst_out_d[i] = 1'b0;
          end
          if (cnt_q == STG_LAST) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: resync = 1'b1;
    endcase

    if (resync) begin
      state_d   = ST_PLL_RST;
      cnt_d     = '0;
      pll_rst_d = 1'b1;
      rst_out_d = '1;
      ready_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_PLL_RST;
      cnt_q     <= '0;
      stb_q     <= '0;
      tmo_q     <= '0;
      pll_rst_q <= 1'b1;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
      loss_q    <= '0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stb_q     <= stb_d;
      tmo_q     <= tmo_d;
      pll_rst_q <= pll_rst_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
      loss_q    <= loss_d;
      terr_q    <= terr_d;
    end
  end

  assign pll_rst         = pll_rst_q;
  assign rst_out         = rst_out_q;
  assign ready           = ready_q;
  assign lock_loss_count = loss_q;
  assign timeout_err     = terr_q;

endmodule
